// File: rtl/bsg_dff_gatestack_driver_pkg.sv
// Shared types and sizing helpers for the gate-stack strobe driver.
// Optional feature macro: BSG_DFF_GATESTACK_DRIVER_SEQ_EN (sequential lane strobing).
package bsg_dff_gatestack_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the shared phase counter; it must hold the largest (N-1) load value.
    function automatic int cnt_width(input int s, input int p, input int h, input int w);
        int m;
        m = max_int(max_int(s, p), max_int(h, w * p));
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // Width of a lane index for a stack of w lanes.
    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bsg_dff_gatestack_driver_if.sv
// Word/handshake bundle between a word source and the gate-stack strobe driver.
// The driver uses the slave modport; the word source uses the master modport.
interface bsg_dff_gatestack_driver_if #(
    parameter int width_p = 16
);
    logic               v_i;
    logic               ready_o;
    logic [width_p-1:0] data_i;
    logic [width_p-1:0] mask_i;
    logic [width_p-1:0] data_o;
    logic [width_p-1:0] strobe_o;
    logic               done_o;

    modport master (
        output v_i, data_i, mask_i,
        input  ready_o, data_o, strobe_o, done_o
    );

    modport slave (
        input  v_i, data_i, mask_i,
        output ready_o, data_o, strobe_o, done_o
    );
endinterface

// File: rtl/bsg_dff_gatestack_driver_timer.sv
// Loadable down-counter with a zero flag, shared by every phase of the driver FSM.
module bsg_dff_gatestack_driver_timer #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               i_load,
    input  logic [width_p-1:0] i_load_val,
    output logic [width_p-1:0] o_count,
    output logic               o_zero
);
    logic [width_p-1:0] r_count;

    // Load on phase entry, otherwise count down and rest at zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);
endmodule

// File: rtl/bsg_dff_gatestack_driver.sv
// Source side of a per-bit-clocked flop stack: presents a word on data_o, then
// raises per-lane strobes so each downstream flop captures its bit on the rising edge.
// Optional feature macro: BSG_DFF_GATESTACK_DRIVER_SEQ_EN -- strobe lanes one at a time.
module bsg_dff_gatestack_driver
    import bsg_dff_gatestack_driver_pkg::*;
#(
    parameter int width_p        = 16,
    parameter int setup_cycles_p = 1,
    parameter int pulse_cycles_p = 2,
    parameter int hold_cycles_p  = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    bsg_dff_gatestack_driver_if.slave    bus
);
    if (width_p < 1 || setup_cycles_p < 1 || pulse_cycles_p < 1 || hold_cycles_p < 1) begin : g_bad_param
        $error("bsg_dff_gatestack_driver: width_p and all phase lengths must be >= 1");
    end

    localparam int cnt_w_lp = cnt_width(setup_cycles_p, pulse_cycles_p, hold_cycles_p, width_p);
    localparam logic [cnt_w_lp-1:0] setup_ld_lp = cnt_w_lp'(setup_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] pulse_ld_lp = cnt_w_lp'(pulse_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0] hold_ld_lp  = cnt_w_lp'(hold_cycles_p - 1);

    state_e               r_state;
    logic [width_p-1:0]   r_data;
    logic [width_p-1:0]   r_mask;
    logic [width_p-1:0]   r_strobe;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_load;
    logic [cnt_w_lp-1:0]  w_load_val;
    logic [cnt_w_lp-1:0]  w_count;
    logic                 w_zero;
    logic                 w_pulse_end;

    assign bus.ready_o  = (r_state == IDLE) & ~reset_i;
    assign w_accept     = bus.v_i & bus.ready_o;
    assign bus.data_o   = r_data;
    assign bus.strobe_o = r_strobe;
    assign bus.done_o   = r_done;

`ifdef BSG_DFF_GATESTACK_DRIVER_SEQ_EN
    localparam int lane_w_lp = idx_width(width_p);
    localparam logic [lane_w_lp-1:0] last_lane_lp = lane_w_lp'(width_p - 1);

    logic [lane_w_lp-1:0] r_lane;
    logic [lane_w_lp-1:0] w_next_lane;
    logic [width_p-1:0]   w_seq_strobe;

    // Lane 0 starts the walk when leaving SETUP; later slots advance by one.
    assign w_next_lane = (r_state == SETUP) ? '0 : r_lane + 1'b1;
    assign w_pulse_end = w_zero & (r_lane == last_lane_lp);

    // One-hot of the next lane, gated by the captured mask (unmasked lanes still use their slot).
    for (genvar gi = 0; gi < width_p; gi++) begin : g_lane
        assign w_seq_strobe[gi] = r_mask[gi] & (w_next_lane == lane_w_lp'(gi));
    end
`else
    assign w_pulse_end = w_zero;
`endif

    bsg_dff_gatestack_driver_timer #(.width_p(cnt_w_lp)) timer (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // Reload the shared timer with (N-1) whenever a new phase (or lane slot) begins.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_load     = 1'b1;
                w_load_val = setup_ld_lp;
            end
            SETUP: if (w_zero) begin
                w_load     = 1'b1;
                w_load_val = pulse_ld_lp;
            end
            PULSE: if (w_zero) begin
                w_load     = 1'b1;
                w_load_val = w_pulse_end ? hold_ld_lp : pulse_ld_lp;
            end
            default: ;
        endcase
    end

    // Phase sequencer; strobe and done come straight from flops so they never glitch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_mask   <= '0;
            r_strobe <= '0;
            r_done   <= 1'b0;
`ifdef BSG_DFF_GATESTACK_DRIVER_SEQ_EN
            r_lane   <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_strobe <= '0;
                    if (w_accept) begin
                        r_data  <= bus.data_i;
                        r_mask  <= bus.mask_i;
                        r_state <= SETUP;
                    end
                end
                SETUP: if (w_zero) begin
                    r_state <= PULSE;
`ifdef BSG_DFF_GATESTACK_DRIVER_SEQ_EN
                    r_lane   <= w_next_lane;
                    r_strobe <= w_seq_strobe;
`else
                    r_strobe <= r_mask;
`endif
                end
                PULSE: begin
                    if (w_pulse_end) begin
                        r_state  <= HOLD;
                        r_strobe <= '0;
                        r_done   <= (hold_cycles_p == 1);
                    end
`ifdef BSG_DFF_GATESTACK_DRIVER_SEQ_EN
                    else if (w_zero) begin
                        r_lane   <= w_next_lane;
                        r_strobe <= w_seq_strobe;
                    end
`endif
                end
                HOLD: begin
                    if (w_zero) begin
                        r_state <= IDLE;
                    end else begin
                        r_done <= (w_count == cnt_w_lp'(1));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
